fp_addsub_norm_pipe: RTL and testbench
======================================

# fp_addsub_norm_pipe

- Parametrised, two-stage pipelined normalisation stage for the floating-point add/sub datapath.
- Takes the raw sum from the mantissa adder and the common exponent, and produces the normalised mantissa, the adjusted exponent and the guard/round/sticky bits for the rounding stage.
- It computes its own leading-zero count, handles carry-out, can optionally clamp underflow to subnormal form, and carries a sideband tag.
- Flow control is valid/ready with full back-pressure.

## Interface
- `EXP_W`, 8: exponent width (5 for FP16, 8 for FP32/BF16).
- `MAN_W`, 23: stored mantissa width (10 for FP16, 7 for BF16).
- `TAG_W`, 4: sideband width (sign, op id), passed through unchanged.
- `SAT_DENORM`, 0: 1 clamps the left shift so the result exponent never goes below 0 (subnormal output).
- Derived `SUM_W = MAN_W+10`, `SW = MAN_W+10-MAN_W-4 = 6` sticky bits.
- `clk` in, 1 bit: clock. One clock; all state on the rising edge.
- `rst` in, 1 bit: synchronous, active-high reset.
- `in_valid` in, 1 bit: input beat valid.
- `in_ready` out, 1 bit: stage 1 can accept a beat.
- `sum` in, `SUM_W` bits: unsigned adder result.
  - bit `SUM_W-1` is carry; bit `SUM_W-2` is the hidden one.
  - bits `[SUM_W-3:SW+2]` are the mantissa; bit `SW+1` is G; bit `SW` is R; bits `[SW-1:0]` are sticky.
- `c_exp` in, `EXP_W` bits: common (larger) biased exponent.
- `tag` in, `TAG_W` bits: sideband.
- `out_valid` out, 1 bit: output beat valid.
- `out_ready` in, 1 bit: downstream accepts.
- `norm_m` out, `MAN_W` bits: normalised mantissa, hidden bit dropped.
- `norm_e` out, `EXP_W+2` bits: signed two's-complement adjusted exponent.
- `neg_e` out, 1 bit: `norm_e < 0`.
- `ovf` out, 1 bit: `norm_e >= 2^EXP_W-1`.
- `zero_sum` out, 1 bit: `sum` was all zero.
- `g`, `r`, `s` out, 1 bit each: guard, round, sticky.
- `tag_o` out, `TAG_W` bits: sideband.

## Operation
- **Stage 1** (registered on accept):
  - `zero = ~|sum`.
  - `lz` = leading zeros of `sum[SUM_W-2:0]`, range 0..`SUM_W-1`.
  - If `SAT_DENORM=1` and `lz >= c_exp`, `lz` is limited to `max(c_exp-1, 0)` and the `den` flag is set.
  - Registers `sum`, `c_exp`, `lz`, `zero`, `den`, `tag`.
- **Stage 2** (registered on advance):
  - **Carry set:** shift right by 1; `norm_e = c_exp+1`. `norm_m = sum[SUM_W-2:SW+3]`, `g = sum[SW+2]`, `r = sum[SW+1]`, `s = |sum[SW:0]`. The shifted-out bit feeds the sticky.
  - **Carry clear:** shift left by `lz` through a log-structured barrel shifter (power-of-two levels, zero fill). Then `norm_e = c_exp - lz`, and mantissa/G/R/S are taken from the fixed fields above.
  - **Denormal:** if `den` is set, `norm_e = 0` and the hidden bit may be 0.
  - **Zero:** `zero_sum=1`, `norm_e=0`, `norm_m=0`, `g=r=s=0`, `neg_e=0`, `ovf=0`.
  - Exponent arithmetic is done at `EXP_W+2` bits, sign-extended; no wrap is possible.
- **Handshake:**
  - `adv2 = ~out_valid | out_ready`.
  - `adv1 = ~s1_valid | adv2`.
  - `in_ready = adv1`; a beat is accepted on `in_valid & in_ready`.
  - A beat moves to stage 2 on `s1_valid & adv2`.
  - Output transfer happens on `out_valid & out_ready`.
  - Output fields stay stable while `out_valid & ~out_ready`.
- **Boundary cases:**
  - Simultaneous accept and output transfer sustains full throughput (1 beat/clk).
  - A bubble in stage 1 clears `out_valid` after the transfer.
  - Order is always preserved.

## Timing
- **Latency:** 2 clocks from input accept to `out_valid`, with `out_ready` held high. Throughput is 1 beat/clk.
- **Reset:**
  - `s1_valid = 0` and `out_valid = 0`, so `in_ready = 1`.
  - All data outputs are 0: `norm_m`, `norm_e`, `neg_e`, `ovf`, `zero_sum`, `g`, `r`, `s`, `tag_o`.
- **Reset mid-stream:** in-flight beats are discarded with no partial output. `in_ready` is 1 in the cycle after reset deasserts.
- **Back-pressure:** up to 2 beats are buffered. With `out_ready` low and both stages full, `in_ready` is low in the same cycle (combinational).
- **Critical path:** LZC in stage 1; shifter plus exponent subtract in stage 2.

## Test plan
All vectors use FP32 (`SUM_W=33`, `SW=6`).
1. **Already normalised:** `sum=33'h0_8000_0000`, `c_exp=127` → after 2 clks `norm_e=127`, `norm_m=0`, `g=r=s=0`, `neg_e=0`.
2. **Carry-out:**
   - `sum=33'h1_0000_0001`, `c_exp=127` → `norm_e=128`, `norm_m=0`, `s=1`.
   - Same `sum` with `c_exp=254` → `norm_e=255`, `ovf=1`.
3. **Large left shift:** `sum=33'h0_0000_0100`, `c_exp=100` → `lz=23`, `norm_e=77`, `norm_m=0`, `g=r=s=0`.
4. **Underflow:** `sum=33'h0_0000_0100`, `c_exp=10`.
   - `SAT_DENORM=0` → `norm_e=-13`, `neg_e=1`.
   - `SAT_DENORM=1` → `norm_e=0`, `norm_m=23'h000200`, `neg_e=0`.
5. **Zero:** `sum=0`, `c_exp=77` → `zero_sum=1`, `norm_e=0`, `norm_m=0`, `g=r=s=0`.
6. **Flow control:**
   - 4 back-to-back beats (tags 1..4) with `out_ready` low for 3 clks: `in_ready` drops after 2 accepted, outputs stay stable, and tags arrive 1..4 with none lost or duplicated.
   - `rst` asserted mid-stream → `out_valid=0`, `in_ready=1` next clk.

Source files
------------

// File: rtl/fp_addsub_norm_pipe.sv
// Two-stage normalisation for the FP add/sub datapath: stage 1 counts leading zeros,
// stage 2 shifts the raw sum into place and produces mantissa, exponent and G/R/S.
module fp_addsub_norm_pipe #(
    parameter int EXP_W      = 8,
    parameter int MAN_W      = 23,
    parameter int TAG_W      = 4,
    parameter int SAT_DENORM = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MAN_W+9:0] sum,
    input  logic [EXP_W-1:0] c_exp,
    input  logic [TAG_W-1:0] tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MAN_W-1:0] norm_m,
    output logic [EXP_W+1:0] norm_e,
    output logic             neg_e,
    output logic             ovf,
    output logic             zero_sum,
    output logic             g,
    output logic             r,
    output logic             s,
    output logic [TAG_W-1:0] tag_o
);

    localparam int SUM_W = MAN_W + 10;
    localparam int SW    = SUM_W - MAN_W - 4;
    localparam int LZ_W  = $clog2(SUM_W);
    localparam int XW    = EXP_W + 2;
    localparam logic [XW-1:0] EMAX = {2'b00, {EXP_W{1'b1}}};

    // Handshake: a beat moves whenever valid and ready are both high on a rising edge;
    // a stage may load when it is empty or its content leaves in the same cycle.
    logic w_adv1, w_adv2;

    logic             r_s1_valid;
    logic [SUM_W-1:0] r_s1_sum;
    logic [EXP_W-1:0] r_s1_cexp;
    logic [LZ_W-1:0]  r_s1_lz;
    logic             r_s1_zero;
    logic             r_s1_den;
    logic [TAG_W-1:0] r_s1_tag;

    logic             r_out_valid;
    logic [MAN_W-1:0] r_norm_m;
    logic [XW-1:0]    r_norm_e;
    logic             r_neg_e, r_ovf, r_zero_sum, r_g, r_r, r_s;
    logic [TAG_W-1:0] r_tag_o;

    assign w_adv2   = ~r_out_valid | out_ready;
    assign w_adv1   = ~r_s1_valid | w_adv2;
    assign in_ready = w_adv1;

    function automatic logic [LZ_W-1:0] f_lzc(input logic [SUM_W-2:0] v);
        logic [LZ_W-1:0] n;
        logic            done;
        n    = '0;
        done = 1'b0;
        for (int i = SUM_W - 2; i >= 0; i--) begin
            if (!done) begin
                if (v[i]) done = 1'b1;
                else      n    = n + 1'b1;
            end
        end
        return n;
    endfunction

    logic [LZ_W-1:0] w_lz_raw, w_lz;
    logic            w_zero, w_den;
    logic [XW-1:0]   w_lz_x, w_cexp_x, w_cexp_m1;

    assign w_lz_raw  = f_lzc(sum[SUM_W-2:0]);
    assign w_zero    = ~|sum;
    assign w_lz_x    = {{(XW-LZ_W){1'b0}}, w_lz_raw};
    assign w_cexp_x  = {2'b00, c_exp};
    assign w_cexp_m1 = w_cexp_x - 1'b1;

    // Subnormal clamp: stop the shift one short of exponent zero so the result stays denormal.
    always_comb begin
        w_lz  = w_lz_raw;
        w_den = 1'b0;
        if (SAT_DENORM != 0 && w_lz_x >= w_cexp_x) begin
            w_den = 1'b1;
            w_lz  = (c_exp == '0) ? '0 : w_cexp_m1[LZ_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sum   <= '0;
            r_s1_cexp  <= '0;
            r_s1_lz    <= '0;
            r_s1_zero  <= 1'b0;
            r_s1_den   <= 1'b0;
            r_s1_tag   <= '0;
        end else begin
            if (w_adv1) r_s1_valid <= in_valid;
            if (in_valid && w_adv1) begin
                r_s1_sum  <= sum;
                r_s1_cexp <= c_exp;
                r_s1_lz   <= w_lz;
                r_s1_zero <= w_zero;
                r_s1_den  <= w_den;
                r_s1_tag  <= tag;
            end
        end
    end

    logic [SUM_W-2:0] w_shl [0:LZ_W];
    assign w_shl[0] = r_s1_sum[SUM_W-2:0];

    genvar k;
    generate
        for (k = 0; k < LZ_W; k++) begin : g_shl
            assign w_shl[k+1] = r_s1_lz[k] ? (w_shl[k] << (1 << k)) : w_shl[k];
        end
    endgenerate

    logic [SUM_W-2:0] w_sh;
    logic [MAN_W-1:0] w_m;
    logic [XW-1:0]    w_e;
    logic             w_g, w_r, w_s, w_neg, w_ovf;

    assign w_sh = w_shl[LZ_W];

    always_comb begin
        w_m = w_sh[SUM_W-3:SW+2];
        w_g = w_sh[SW+1];
        w_r = w_sh[SW];
        w_s = |w_sh[SW-1:0];
        w_e = r_s1_den ? '0 : (w_cexp2_x() - {{(XW-LZ_W){1'b0}}, r_s1_lz});
        if (r_s1_zero) begin
            w_m = '0;
            w_g = 1'b0;
            w_r = 1'b0;
            w_s = 1'b0;
            w_e = '0;
        end else if (r_s1_sum[SUM_W-1]) begin
            // Carry-out: one right shift, the dropped LSB folds into sticky.
            w_m = r_s1_sum[SUM_W-2:SW+3];
            w_g = r_s1_sum[SW+2];
            w_r = r_s1_sum[SW+1];
            w_s = |r_s1_sum[SW:0];
            w_e = w_cexp2_x() + 1'b1;
        end
    end

    function automatic logic [XW-1:0] w_cexp2_x();
        return {2'b00, r_s1_cexp};
    endfunction

    assign w_neg = w_e[XW-1];
    assign w_ovf = ~w_e[XW-1] & (w_e >= EMAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_norm_m    <= '0;
            r_norm_e    <= '0;
            r_neg_e     <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero_sum  <= 1'b0;
            r_g         <= 1'b0;
            r_r         <= 1'b0;
            r_s         <= 1'b0;
            r_tag_o     <= '0;
        end else begin
            if (w_adv2) r_out_valid <= r_s1_valid;
            if (r_s1_valid && w_adv2) begin
                r_norm_m   <= w_m;
                r_norm_e   <= w_e;
                r_neg_e    <= w_neg;
                r_ovf      <= w_ovf;
                r_zero_sum <= r_s1_zero;
                r_g        <= w_g;
                r_r        <= w_r;
                r_s        <= w_s;
                r_tag_o    <= r_s1_tag;
            end
        end
    end

    logic w_unused;
    assign w_unused = &{1'b0, w_sh[SUM_W-2], w_cexp_m1[XW-1:LZ_W]};

    assign out_valid = r_out_valid;
    assign norm_m    = r_norm_m;
    assign norm_e    = r_norm_e;
    assign neg_e     = r_neg_e;
    assign ovf       = r_ovf;
    assign zero_sum  = r_zero_sum;
    assign g         = r_g;
    assign r         = r_r;
    assign s         = r_s;
    assign tag_o     = r_tag_o;

endmodule

// File: tb/tb_fp_addsub_norm_pipe.sv
// Bench for fp_addsub_norm_pipe (FP32): two instances, plain and subnormal-clamping,
// driven in lockstep; results are predicted from the position of the sum's leading one.
module tb_fp_addsub_norm_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, out_ready;
  logic [32:0] sum;
  logic [7:0]  c_exp;
  logic [3:0]  tag;

  logic        in_ready_0, out_valid_0, neg_e_0, ovf_0, zero_sum_0, g_0, r_0, s_0;
  logic [22:0] norm_m_0;
  logic [9:0]  norm_e_0;
  logic [3:0]  tag_o_0;
  logic        in_ready_1, out_valid_1, neg_e_1, ovf_1, zero_sum_1, g_1, r_1, s_1;
  logic [22:0] norm_m_1;
  logic [9:0]  norm_e_1;
  logic [3:0]  tag_o_1;

  fp_addsub_norm_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4), .SAT_DENORM(0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_0), .sum(sum),
    .c_exp(c_exp), .tag(tag), .out_valid(out_valid_0), .out_ready(out_ready),
    .norm_m(norm_m_0), .norm_e(norm_e_0), .neg_e(neg_e_0), .ovf(ovf_0),
    .zero_sum(zero_sum_0), .g(g_0), .r(r_0), .s(s_0), .tag_o(tag_o_0)
  );

  fp_addsub_norm_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4), .SAT_DENORM(1)) u_dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_1), .sum(sum),
    .c_exp(c_exp), .tag(tag), .out_valid(out_valid_1), .out_ready(out_ready),
    .norm_m(norm_m_1), .norm_e(norm_e_1), .neg_e(neg_e_1), .ovf(ovf_1),
    .zero_sum(zero_sum_1), .g(g_1), .r(r_1), .s(s_1), .tag_o(tag_o_1)
  );

  logic [42:0] obs0, obs1;
  assign obs0 = {tag_o_0, zero_sum_0, ovf_0, neg_e_0, norm_e_0, norm_m_0, g_0, r_0, s_0};
  assign obs1 = {tag_o_1, zero_sum_1, ovf_1, neg_e_1, norm_e_1, norm_m_1, g_1, r_1, s_1};

  int n_checks = 0;
  int n_pass   = 0;
  int n_out    = 0;

  logic [42:0] exp_q0[$];
  logic [42:0] exp_q1[$];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [42:0] pack(input logic [3:0] t, input logic z, input logic o,
                                       input logic n, input logic [9:0] e,
                                       input logic [22:0] m, input logic gg,
                                       input logic rr, input logic ss);
    return {t, z, o, n, e, m, gg, rr, ss};
  endfunction

  // Reference: locate the leading one, align it to bit 31, read the fixed fields.
  function automatic logic [42:0] model(input logic [32:0] sv, input logic [7:0] c,
                                        input logic [3:0] t, input bit sat);
    logic [63:0] a;
    int p, lz, e;
    bit den, lost;
    if (sv == '0) return pack(t, 1'b1, 1'b0, 1'b0, 10'd0, 23'd0, 1'b0, 1'b0, 1'b0);
    p = -1;
    for (int i = 0; i < 33; i++) if (sv[i]) p = i;
    den  = 0;
    lost = 0;
    if (p == 32) begin
      a    = 64'(sv) >> 1;
      lost = sv[0];
      e    = int'(c) + 1;
    end else begin
      lz = 31 - p;
      if (sat && lz >= int'(c)) begin
        lz  = (c > 0) ? int'(c) - 1 : 0;
        den = 1;
      end
      a = 64'(sv) << lz;
      e = den ? 0 : int'(c) - lz;
    end
    return pack(t, 1'b0, logic'(e >= 255), logic'(e < 0), 10'(e), a[30:8], a[7], a[6],
                (|a[5:0]) | lost);
  endfunction

  // Scoreboard and stall-stability monitor, sampled on the falling edge.
  bit          stall_prev = 0;
  logic [85:0] held;
  logic [42:0] e_front;
  always @(negedge clk) begin
    if (rst) begin
      exp_q0.delete();
      exp_q1.delete();
      stall_prev = 0;
    end else begin
      if (out_valid_0 && out_ready) begin
        if (exp_q0.size() == 0 || exp_q1.size() == 0) begin
          check("unexpected_out", 96'(1), 96'(0));
        end else begin
          e_front = exp_q0.pop_front();
          check("out_sat0", 96'(obs0), 96'(e_front));
          e_front = exp_q1.pop_front();
          check("out_sat1", 96'({out_valid_1, obs1}), 96'({1'b1, e_front}));
          n_out++;
        end
      end
      if (stall_prev) check("stall_stable", 96'({out_valid_0, obs0, obs1}), 96'({1'b1, held}));
      stall_prev = out_valid_0 && !out_ready;
      held       = {obs0, obs1};
      if (in_valid && in_ready_0) begin
        exp_q0.push_back(model(sum, c_exp, tag, 1'b0));
        exp_q1.push_back(model(sum, c_exp, tag, 1'b1));
      end
    end
  end

  task automatic directed(input string name, input logic [32:0] sv, input logic [7:0] c,
                          input logic [3:0] t, input logic [42:0] x0, input logic [42:0] x1);
    @(posedge clk); #1;
    in_valid = 1'b1; sum = sv; c_exp = c; tag = t; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check({name, "_valid"}, 96'(out_valid_0), 96'(1));
    check({name, "_sat0"}, 96'(obs0), 96'(x0));
    check({name, "_sat1"}, 96'(obs1), 96'(x1));
  endtask

  task automatic drive_beat(input logic [32:0] sv, input logic [7:0] c, input logic [3:0] t);
    int waited;
    bit acc;
    waited = 0;
    in_valid = 1'b1; sum = sv; c_exp = c; tag = t;
    do begin
      @(negedge clk); acc = in_ready_0;
      @(posedge clk); #1;
      waited++;
    end while (!acc && waited < 20);
    if (!acc) check("accept_timeout", 96'(0), 96'(1));
  endtask

  task automatic rand_data();
    logic [32:0] v;
    v = {1'($urandom_range(0, 1)), $urandom};
    if ($urandom_range(0, 15) == 0) v = '0;
    else v = v >> $urandom_range(0, 33);
    sum   = v;
    c_exp = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 255));
    tag   = 4'($urandom_range(0, 15));
  endtask

  task automatic drain(input string name);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 30 && (exp_q0.size() != 0 || out_valid_0); i++) begin
      @(posedge clk); #1;
    end
    check(name, 96'({exp_q0.size(), out_valid_0}), 96'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    bit acc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sum = '0; c_exp = '0; tag = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 96'({in_ready_0, in_ready_1}), 96'(2'b11));
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 96'({out_valid_0, out_valid_1}), 96'(0));
    check("rst_data", 96'({obs0, obs1}), 96'(0));
    check("rst_ready_after", 96'(in_ready_0), 96'(1));

    directed("normalised", 33'h0_8000_0000, 8'd127, 4'd1,
             pack(4'd1, 0, 0, 0, 10'd127, 23'd0, 0, 0, 0),
             pack(4'd1, 0, 0, 0, 10'd127, 23'd0, 0, 0, 0));
    directed("carry", 33'h1_0000_0001, 8'd127, 4'd2,
             pack(4'd2, 0, 0, 0, 10'd128, 23'd0, 0, 0, 1),
             pack(4'd2, 0, 0, 0, 10'd128, 23'd0, 0, 0, 1));
    directed("carry_ovf", 33'h1_0000_0001, 8'd254, 4'd3,
             pack(4'd3, 0, 1, 0, 10'd255, 23'd0, 0, 0, 1),
             pack(4'd3, 0, 1, 0, 10'd255, 23'd0, 0, 0, 1));
    directed("big_shift", 33'h0_0000_0100, 8'd100, 4'd4,
             pack(4'd4, 0, 0, 0, 10'd77, 23'd0, 0, 0, 0),
             pack(4'd4, 0, 0, 0, 10'd77, 23'd0, 0, 0, 0));
    directed("underflow", 33'h0_0000_0100, 8'd10, 4'd5,
             pack(4'd5, 0, 0, 1, 10'h3F3, 23'd0, 0, 0, 0),
             pack(4'd5, 0, 0, 0, 10'd0, 23'h000200, 0, 0, 0));
    directed("zero", 33'h0, 8'd77, 4'd6,
             pack(4'd6, 1, 0, 0, 10'd0, 23'd0, 0, 0, 0),
             pack(4'd6, 1, 0, 0, 10'd0, 23'd0, 0, 0, 0));
    directed("cexp_zero", 33'h0_0000_0100, 8'd0, 4'd7,
             pack(4'd7, 0, 0, 1, 10'h3E9, 23'd0, 0, 0, 0),
             pack(4'd7, 0, 0, 0, 10'd0, 23'h000001, 0, 0, 0));
    directed("carry_sticky", 33'h1_FFFF_FFFF, 8'd1, 4'd8,
             pack(4'd8, 0, 0, 0, 10'd2, 23'h7FFFFF, 1, 1, 1),
             pack(4'd8, 0, 0, 0, 10'd2, 23'h7FFFFF, 1, 1, 1));
    drain("drain_directed");

    // Back-pressure: out_ready low for three clocks while four beats are offered.
    base = n_out;
    @(posedge clk); #1;
    out_ready = 1'b0;
    fork
      begin
        for (int t = 1; t <= 4; t++) begin
          rand_data();
          drive_beat(sum, c_exp, 4'(t));
        end
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(negedge clk);
        check("in_ready_full", 96'(in_ready_0), 96'(0));
        check("flow_head_tag", 96'({out_valid_0, tag_o_0}), 96'({1'b1, 4'd1}));
        @(posedge clk); #1;
        out_ready = 1'b1;
        #1;
        check("in_ready_comb", 96'(in_ready_0), 96'(1));
      end
    join
    drain("drain_flow");
    check("flow_count", 96'(n_out - base), 96'(4));

    // Randomised traffic with random back-pressure.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      acc = in_valid && in_ready_0;
      @(posedge clk); #1;
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        rand_data();
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    drain("drain_random");

    // Reset with both stages full: everything in flight is dropped.
    @(posedge clk); #1;
    out_ready = 1'b0;
    rand_data();
    drive_beat(sum, c_exp, 4'd9);
    rand_data();
    drive_beat(sum, c_exp, 4'd10);
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_valid", 96'({out_valid_0, out_valid_1}), 96'(0));
    check("rst_mid_ready", 96'({in_ready_0, in_ready_1}), 96'(2'b11));
    check("rst_mid_data", 96'({obs0, obs1}), 96'(0));
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst_mid_quiet", 96'(out_valid_0), 96'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
